// File: rtl/disp_share_arbiter.sv
// Round-robin owner selection for the shared 2-digit display scanner.
// Grants are held for at least MIN_MS ticks and may be preempted after MAX_MS ticks.
module disp_share_arbiter #(
    parameter int          MCNT_TICK = 50000 - 1,
    parameter int          MIN_MS    = 500,
    parameter int          MAX_MS    = 2000,
    parameter logic [7:0]  IDLE_DATA = 8'h00
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [2:0]  Req,
    input  logic [23:0] Req_Data,
    output logic [2:0]  Gnt,
    output logic [1:0]  Owner,
    output logic        Busy,
    output logic [7:0]  Disp_Data
);

    localparam int TW = (MCNT_TICK < 1) ? 1 : $clog2(MCNT_TICK + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1,
        S_SWITCH = 2'd2
    } state_t;

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic [15:0]   hold_cnt;
    logic [1:0]    rr_last;

    logic          tick;
    logic [1:0]    win;
    logic          req_cur;
    logic          other_req;
    logic          min_done;
    logic          max_done;

    function automatic logic [7:0] sel_data(input logic [1:0] idx, input logic [23:0] data);
        case (idx)
            2'd0:    return data[7:0];
            2'd1:    return data[15:8];
            default: return data[23:16];
        endcase
    endfunction

    assign tick      = (tick_cnt == TW'(MCNT_TICK));
    assign other_req = |(Req & ~Gnt);
    assign min_done  = (hold_cnt >= 16'(MIN_MS));
    assign max_done  = (hold_cnt >= 16'(MAX_MS));
    assign Busy      = (state != S_IDLE);

    // Scan starts one past the previous owner, wrapping mod 3.
    always_comb begin
        win = 2'd0;
        case (rr_last)
            2'd0:    win = Req[1] ? 2'd1 : (Req[2] ? 2'd2 : 2'd0);
            2'd1:    win = Req[2] ? 2'd2 : (Req[0] ? 2'd0 : 2'd1);
            default: win = Req[0] ? 2'd0 : (Req[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        req_cur = 1'b0;
        case (Owner)
            2'd0:    req_cur = Req[0];
            2'd1:    req_cur = Req[1];
            2'd2:    req_cur = Req[2];
            default: req_cur = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= S_IDLE;
            tick_cnt  <= '0;
            hold_cnt  <= '0;
            rr_last   <= 2'd2;
            Gnt       <= 3'b000;
            Owner     <= 2'b11;
            Disp_Data <= IDLE_DATA;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    Disp_Data <= IDLE_DATA;
                    if (|Req) begin
                        state     <= S_GRANT;
                        Gnt       <= 3'b001 << win;
                        Owner     <= win;
                        rr_last   <= win;
                        Disp_Data <= sel_data(win, Req_Data);
                        tick_cnt  <= '0;
                        hold_cnt  <= '0;
                    end
                end
                S_GRANT: begin
                    if (tick && hold_cnt != 16'hFFFF)
                        hold_cnt <= hold_cnt + 16'd1;
                    // A dropped request freezes the last captured byte.
                    if (req_cur)
                        Disp_Data <= sel_data(Owner, Req_Data);
                    if ((min_done && !req_cur) || (max_done && other_req)) begin
                        state <= S_SWITCH;
                        Gnt   <= 3'b000;
                        Owner <= 2'b11;
                    end
                end
                S_SWITCH: begin
                    state     <= S_IDLE;
                    Disp_Data <= IDLE_DATA;
                end
                default: begin
                    state <= S_IDLE;
                    Gnt   <= 3'b000;
                    Owner <= 2'b11;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_disp_share_arbiter.sv
// Directed bench for disp_share_arbiter with 10-cycle ticks, MIN_MS=3, MAX_MS=10.
module tb_disp_share_arbiter;

    logic        Clk;
    logic        Reset_n;
    logic [2:0]  Req;
    logic [23:0] Req_Data;
    logic [2:0]  Gnt;
    logic [1:0]  Owner;
    logic        Busy;
    logic [7:0]  Disp_Data;

    int n_cmp = 0;
    int n_err = 0;

    disp_share_arbiter #(
        .MCNT_TICK (9),
        .MIN_MS    (3),
        .MAX_MS    (10),
        .IDLE_DATA (8'h00)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Req       (Req),
        .Req_Data  (Req_Data),
        .Gnt       (Gnt),
        .Owner     (Owner),
        .Busy      (Busy),
        .Disp_Data (Disp_Data)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic test_reset();
        cyc(2);
        n_cmp++; if (Gnt !== 3'b000) begin n_err++; $display("FAIL rst_gnt: got %b want 000", Gnt); end
        n_cmp++; if (Owner !== 2'b11) begin n_err++; $display("FAIL rst_owner: got %0d want 3", Owner); end
        n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", Busy); end
        n_cmp++; if (Disp_Data !== 8'h00) begin n_err++; $display("FAIL rst_disp: got %h want 00", Disp_Data); end
        Reset_n = 1'b1;
        Req_Data[7:0] = 8'hA5;
        Req = 3'b001;
        cyc(1);
        n_cmp++; if (Gnt !== 3'b001) begin n_err++; $display("FAIL rst_first_gnt: got %b want 001", Gnt); end
        cyc(4);
        #3 Reset_n = 1'b0;
        #1;
        n_cmp++; if (Gnt !== 3'b000) begin n_err++; $display("FAIL rst_async_gnt: got %b want 000", Gnt); end
        n_cmp++; if (Owner !== 2'b11) begin n_err++; $display("FAIL rst_async_owner: got %0d want 3", Owner); end
        n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL rst_async_busy: got %b want 0", Busy); end
        n_cmp++; if (Disp_Data !== 8'h00) begin n_err++; $display("FAIL rst_async_disp: got %h want 00", Disp_Data); end
        Req = 3'b000;
        cyc(1);
        Reset_n = 1'b1;
        // Both 0 and 1 pending: restored rr_last=2 makes 0 the winner.
        Req = 3'b011;
        cyc(1);
        n_cmp++; if (Gnt !== 3'b001) begin n_err++; $display("FAIL rst_rr_gnt: got %b want 001", Gnt); end
        n_cmp++; if (Owner !== 2'd0) begin n_err++; $display("FAIL rst_rr_owner: got %0d want 0", Owner); end
        n_cmp++; if (Disp_Data !== 8'hA5) begin n_err++; $display("FAIL rst_rr_disp: got %h want a5", Disp_Data); end
        Req = 3'b000;
        cyc(40);
    endtask

    task automatic test_hold_release();
        int bad;
        bad = 0;
        Req_Data[15:8] = 8'h42;
        Req = 3'b010;
        cyc(1);
        n_cmp++; if (Gnt !== 3'b010) begin n_err++; $display("FAIL hold_gnt: got %b want 010", Gnt); end
        n_cmp++; if (Disp_Data !== 8'h42) begin n_err++; $display("FAIL hold_disp: got %h want 42", Disp_Data); end
        n_cmp++; if (Owner !== 2'd1) begin n_err++; $display("FAIL hold_owner: got %0d want 1", Owner); end
        for (int i = 0; i < 199; i++) begin
            cyc(1);
            if (Gnt !== 3'b010) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL hold_steady: got %0d dropped cycles want 0", bad); end
        Req = 3'b000;
        cyc(1);
        n_cmp++; if (Gnt !== 3'b000) begin n_err++; $display("FAIL hold_fall: got %b want 000", Gnt); end
        n_cmp++; if (Busy !== 1'b1) begin n_err++; $display("FAIL hold_switch_busy: got %b want 1", Busy); end
        n_cmp++; if (Disp_Data !== 8'h42) begin n_err++; $display("FAIL hold_switch_disp: got %h want 42", Disp_Data); end
        cyc(1);
        n_cmp++; if (Disp_Data !== 8'h00) begin n_err++; $display("FAIL hold_idle_disp: got %h want 00", Disp_Data); end
        n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL hold_idle_busy: got %b want 0", Busy); end
        cyc(5);
    endtask

    task automatic test_min_hold();
        int hi;
        int bad;
        hi = 0;
        bad = 0;
        Req_Data[7:0] = 8'h15;
        Req = 3'b001;
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            if (i == 4) Req = 3'b000;
            if (Gnt == 3'b001) hi++;
            if (Busy && Disp_Data !== 8'h15) bad++;
        end
        n_cmp++; if (hi != 31) begin n_err++; $display("FAIL min_gnt_len: got %0d cycles want 31", hi); end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL min_disp_hold: got %0d bad cycles want 0", bad); end
        n_cmp++; if (Disp_Data !== 8'h00) begin n_err++; $display("FAIL min_disp_idle: got %h want 00", Disp_Data); end
    endtask

    task automatic test_round_robin();
        logic [2:0] gseq [3];
        logic [2:0] gnext;
        int bad;
        gseq[0] = 3'b001;
        gseq[1] = 3'b010;
        gseq[2] = 3'b100;
        Reset_n = 1'b0;
        cyc(1);
        Reset_n = 1'b1;
        Req_Data = 24'hC3_42_15;
        Req = 3'b111;
        cyc(1);
        n_cmp++; if (Gnt !== 3'b001) begin n_err++; $display("FAIL rr_start: got %b want 001", Gnt); end
        for (int k = 0; k < 3; k++) begin
            gnext = gseq[(k + 1) % 3];
            bad = 0;
            for (int i = 0; i < 100; i++) begin
                cyc(1);
                if (Gnt !== gseq[k]) bad++;
            end
            n_cmp++; if (bad != 0) begin n_err++; $display("FAIL rr_len_%0d: got %0d off cycles want 0", k, bad); end
            cyc(1);
            n_cmp++; if (Gnt !== 3'b000 || Busy !== 1'b1) begin n_err++; $display("FAIL rr_switch_%0d: got gnt %b busy %b want 000 1", k, Gnt, Busy); end
            cyc(1);
            n_cmp++; if (Gnt !== 3'b000 || Busy !== 1'b0) begin n_err++; $display("FAIL rr_idle_%0d: got gnt %b busy %b want 000 0", k, Gnt, Busy); end
            cyc(1);
            n_cmp++; if (Gnt !== gnext) begin n_err++; $display("FAIL rr_next_%0d: got %b want %b", k, Gnt, gnext); end
        end
        n_cmp++; if (Disp_Data !== 8'h15) begin n_err++; $display("FAIL rr_disp: got %h want 15", Disp_Data); end
        Req = 3'b000;
        cyc(40);
    endtask

    task automatic test_no_preempt();
        int bad;
        bad = 0;
        Req = 3'b100;
        cyc(1);
        n_cmp++; if (Gnt !== 3'b100) begin n_err++; $display("FAIL np_gnt: got %b want 100", Gnt); end
        n_cmp++; if (Disp_Data !== 8'hC3) begin n_err++; $display("FAIL np_disp: got %h want c3", Disp_Data); end
        for (int i = 0; i < 299; i++) begin
            cyc(1);
            if (Gnt !== 3'b100) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL np_steady: got %0d off cycles want 0", bad); end
        Req = 3'b101;
        cyc(1);
        n_cmp++; if (Gnt !== 3'b000) begin n_err++; $display("FAIL np_preempt: got %b want 000", Gnt); end
        cyc(1);
        n_cmp++; if (Gnt !== 3'b000) begin n_err++; $display("FAIL np_gap: got %b want 000", Gnt); end
        cyc(1);
        n_cmp++; if (Gnt !== 3'b001) begin n_err++; $display("FAIL np_handover: got %b want 001", Gnt); end
        n_cmp++; if (Disp_Data !== 8'h15) begin n_err++; $display("FAIL np_handover_disp: got %h want 15", Disp_Data); end
        Req = 3'b000;
        cyc(40);
    endtask

    task automatic test_data_follow();
        Req_Data = 24'h00_20_00;
        Req = 3'b010;
        cyc(1);
        n_cmp++; if (Disp_Data !== 8'h20) begin n_err++; $display("FAIL df_first: got %h want 20", Disp_Data); end
        Req_Data[15:8] = 8'h37;
        cyc(1);
        n_cmp++; if (Disp_Data !== 8'h37) begin n_err++; $display("FAIL df_follow: got %h want 37", Disp_Data); end
        Req_Data[7:0] = 8'hEE;
        Req_Data[23:16] = 8'h5A;
        cyc(1);
        n_cmp++; if (Disp_Data !== 8'h37) begin n_err++; $display("FAIL df_nonowner: got %h want 37", Disp_Data); end
        // Drop well before MIN_MS: grant persists and the byte freezes.
        Req = 3'b000;
        Req_Data[15:8] = 8'h99;
        cyc(2);
        n_cmp++; if (Disp_Data !== 8'h37) begin n_err++; $display("FAIL df_frozen: got %h want 37", Disp_Data); end
        n_cmp++; if (Gnt !== 3'b010) begin n_err++; $display("FAIL df_min_hold: got %b want 010", Gnt); end
        cyc(40);
        n_cmp++; if (Busy !== 1'b0 || Gnt !== 3'b000) begin n_err++; $display("FAIL df_released: got busy %b gnt %b want 0 000", Busy, Gnt); end
    endtask

    initial begin
        Reset_n  = 1'b0;
        Req      = 3'b000;
        Req_Data = 24'h0;
        test_reset();
        test_hold_release();
        test_min_hold();
        test_round_robin();
        test_no_preempt();
        test_data_follow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
